// File: rtl/sr_upscale_reader.sv
// Read-side consumer of the superresolution output FIFO: buffers one input line and replays it
// as a 2x nearest-neighbour upscaled valid/ready pixel stream.
module sr_upscale_reader #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter int unsigned PIXEL_WIDTH = 24,
    parameter int unsigned RD_THRESH   = 5
) (
    input  logic                   clk_r,
    input  logic                   rst_n,
    input  logic [9:0]             data_count_r,
    input  logic [PIXEL_WIDTH-1:0] din,
    output logic                   rd_fifo,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic [9:0]             out_x,
    output logic [9:0]             out_y,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   frame_out_done,
    output logic [7:0]             led_r
);

    localparam logic [8:0] LineLen  = 9'(WIDTH);
    localparam logic [8:0] LineLast = 9'(HEIGHT - 1);
    localparam logic [9:0] XLast    = 10'(2 * WIDTH - 1);
    localparam logic [9:0] YLast    = 10'(2 * HEIGHT - 1);
    localparam logic [9:0] Thresh   = 10'(RD_THRESH);

    typedef enum logic [2:0] {StIdle, StFill, StEmit0, StEmit1, StDone} state_t;

    state_t                 r_state, w_state_nxt;
    logic [8:0]             r_reads, r_wr_idx, r_in_line;
    logic                   r_rd_pend;
    logic [9:0]             r_col, w_col_nxt, w_y_nxt;
    logic                   r_prow, r_pdone;
    logic                   w_above, w_emit, w_load, w_accept, w_fill_entry;
    logic                   r_any_rd, r_frame_done;
    logic [PIXEL_WIDTH-1:0] r_linebuf [512];
    logic [PIXEL_WIDTH-1:0] r_pf_pix;
    logic                   r_out_valid, r_out_sof, r_out_eol, r_out_eof;
    logic [PIXEL_WIDTH-1:0] r_out_pixel;
    logic [9:0]             r_out_x, r_out_y;
    logic [7:0]             r_led;

    assign w_above      = data_count_r > Thresh;
    assign w_emit       = (r_state == StEmit0) || (r_state == StEmit1);
    // r_pdone stops the producer once both output rows of the line have been queued
    assign w_load       = w_emit && !r_pdone && (!r_out_valid || out_ready);
    assign w_accept     = r_out_valid && out_ready;
    assign w_col_nxt    = !w_load ? r_col : ((r_col == XLast) ? 10'd0 : r_col + 10'd1);
    assign w_y_nxt      = {r_in_line, r_prow};
    assign w_fill_entry = (r_state != StFill) && (w_state_nxt == StFill);

    always_comb begin
        w_state_nxt    = r_state;
        rd_fifo        = 1'b0;
        frame_out_done = 1'b0;
        case (r_state)
            StIdle:  if (w_above) w_state_nxt = StFill;
            StFill: begin
                rd_fifo = w_above && (r_reads < LineLen);
                if (r_wr_idx == LineLen) w_state_nxt = StEmit0;
            end
            StEmit0: if (w_accept && r_out_eol) w_state_nxt = StEmit1;
            StEmit1: begin
                if (w_accept && r_out_eol) begin
                    w_state_nxt = (r_in_line == LineLast) ? StDone : StFill;
                end
            end
            StDone: begin
                frame_out_done = 1'b1;
                w_state_nxt    = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_reads      <= '0;
            r_wr_idx     <= '0;
            r_in_line    <= '0;
            r_rd_pend    <= 1'b0;
            r_col        <= '0;
            r_prow       <= 1'b0;
            r_pdone      <= 1'b0;
            r_any_rd     <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_pixel  <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_out_sof    <= 1'b0;
            r_out_eol    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_led        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pend    <= rd_fifo;
            r_any_rd     <= r_any_rd | rd_fifo;
            r_frame_done <= r_frame_done | frame_out_done;
            r_led        <= {r_frame_done | frame_out_done, w_above, r_out_valid && !out_ready,
                             r_out_valid, r_any_rd | rd_fifo, r_state};
            if (w_fill_entry) begin
                r_reads   <= '0;
                r_wr_idx  <= '0;
                r_col     <= '0;
                r_prow    <= 1'b0;
                r_pdone   <= 1'b0;
                r_in_line <= (r_state == StIdle) ? 9'd0 : r_in_line + 9'd1;
            end else begin
                if (rd_fifo) r_reads <= r_reads + 9'd1;
                if (r_rd_pend) r_wr_idx <= r_wr_idx + 9'd1;
                r_col <= w_col_nxt;
                if (w_load && (r_col == XLast)) begin
                    if (r_prow) r_pdone <= 1'b1;
                    else        r_prow  <= 1'b1;
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= r_pf_pix;
                r_out_x     <= r_col;
                r_out_y     <= w_y_nxt;
                r_out_sof   <= (r_col == 10'd0) && (w_y_nxt == 10'd0);
                r_out_eol   <= (r_col == XLast);
                r_out_eof   <= (r_col == XLast) && (w_y_nxt == YLast);
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Line buffer and prefetch: r_pf_pix always holds the pixel for the next column to issue
    always_ff @(posedge clk_r) begin
        if (r_rd_pend) r_linebuf[r_wr_idx] <= din;
        r_pf_pix <= r_linebuf[w_col_nxt[9:1]];
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;
    assign led_r     = r_led;

endmodule

// File: tb/tb_sr_upscale_reader.sv
// Scoreboard bench for sr_upscale_reader on a reduced 8x4 frame with a behavioural FIFO model.
module tb_sr_upscale_reader;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = 24;

    logic          clk_r = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    data_count_r;
    logic [PW-1:0] din = '0;
    logic          rd_fifo;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [PW-1:0] out_pixel;
    logic [9:0]    out_x, out_y;
    logic          out_sof, out_eol, out_eof, frame_out_done;
    logic [7:0]    led_r;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    logic       ovr_en = 1'b0;
    logic [9:0] ovr_val = 10'd0;

    logic [PW-1:0] mem [4096];
    int wptr = 0;
    int rptr = 0;
    logic [50:0] exp_q [$];

    sr_upscale_reader #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .RD_THRESH(5)) dut (
        .clk_r(clk_r), .rst_n(rst_n), .data_count_r(data_count_r), .din(din),
        .rd_fifo(rd_fifo), .out_ready(out_ready), .out_valid(out_valid),
        .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .frame_out_done(frame_out_done), .led_r(led_r)
    );

    always #5 clk_r = ~clk_r;

    assign data_count_r = ovr_en ? ovr_val : ((wptr != rptr) ? 10'(wptr - rptr + 5) : 10'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] word(input int f, input int l, input int k);
        return {8'(f), 8'(l), 8'(k)};
    endfunction

    // FIFO model: one word per rd_fifo, presented the following cycle; reset drops queued words
    always @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= wptr;
        end else begin
            if (ovr_en && ovr_val <= 10'd5) chk("stalled_rd", 64'(rd_fifo), 64'd0);
            if (rd_fifo) begin
                chk("underflow", 64'(wptr == rptr), 64'd0);
                din  <= mem[rptr % 4096];
                rptr <= rptr + 1;
            end
        end
    end

    always @(posedge clk_r) begin
        #1 out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: pops on every accepted beat and checks hold-stability during stalls
    logic        prev_stall = 1'b0;
    logic [50:0] prev_beat;
    always @(negedge clk_r) begin
        logic [50:0] beat;
        beat = {out_pixel, out_x, out_y, out_sof, out_eol, out_eof};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_out_done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", 64'(beat), 64'(prev_beat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 64'(beat), 64'd0);
                else chk("beat", 64'(beat), 64'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = beat;
        end
    end

    task automatic push_line(input int f, input int l);
        for (int k = 0; k < W; k++) begin
            mem[wptr % 4096] = word(f, l, k);
            wptr++;
        end
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 2 * W; x++) begin
                int y;
                y = 2 * l + r;
                exp_q.push_back({word(f, l, x >> 1), 10'(x), 10'(y), x == 0 && y == 0,
                                 x == 2 * W - 1, x == 2 * W - 1 && y == 2 * H - 1});
            end
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk_r);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk_r);
            n++;
        end
        repeat (3) @(negedge clk_r);
        chk("done_count", 64'(done_cnt), 64'(target));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rd_fifo", 64'(rd_fifo), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_xy", 64'({out_x, out_y}), 64'd0);
        chk("rst_led", 64'(led_r), 64'd0);
        chk("rst_flags", 64'({out_sof, out_eol, out_eof, frame_out_done}), 64'd0);
    endtask

    initial begin
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk_r);
        rst_n = 1'b1;

        // Frame 0: line 0 full rate, line 1 random backpressure
        rdy_mode = 0;
        push_line(0, 0);
        wait_empty("line0");
        rdy_mode = 1;
        push_line(0, 1);
        wait_empty("line1");

        // Line 2: count pinned at threshold, a short burst above it, then pinned again
        ovr_en = 1'b1;
        ovr_val = 10'd5;
        push_line(0, 2);
        repeat (20) @(negedge clk_r);
        ovr_val = 10'd6;
        repeat (3) @(negedge clk_r);
        ovr_val = 10'd5;
        repeat (10) @(negedge clk_r);
        ovr_en = 1'b0;
        wait_empty("line2");
        rdy_mode = 0;
        push_line(0, 3);
        wait_empty("line3");
        wait_done(1);
        chk("idle_after_frame", 64'(led_r[2:0]), 64'd0);
        chk("led_frame_done", 64'(led_r[7]), 64'd1);

        // Frame 1 aborted by reset during an odd (second-copy) output row
        rdy_mode = 1;
        for (int l = 0; l < H; l++) push_line(1, l);
        begin
            int n;
            n = 0;
            while (!(out_valid && out_y == 10'd3) && n < 3000) begin
                @(negedge clk_r);
                n++;
            end
            chk("reach_row3", 64'(out_valid && out_y == 10'd3), 64'd1);
        end
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk_r);
        rst_n = 1'b1;

        // Frame 2: first beat must be a fresh sof at (0,0)
        for (int l = 0; l < H; l++) push_line(2, l);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 3000) begin
                @(negedge clk_r);
                n++;
            end
            chk("first_sof", 64'({out_valid, out_sof, out_x, out_y}), 64'({1'b1, 1'b1, 20'd0}));
            chk("first_pixel", 64'(out_pixel), 64'(word(2, 0, 0)));
        end
        wait_empty("frame2");
        wait_done(2);
        chk("final_idle", 64'(led_r[2:0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
